clk_edge_monitor: RTL and testbench
===================================

Name: clk_edge_monitor

Overview:
- Consumer side of the divided-clock path: receives a slow clock such as a divider's oclk, asynchronous to the system clock.
- Brings it into the fast clk domain and emits single-cycle rising and falling edge strobes, so CPU stages can step on clock enables instead of a derived clock.
- Measures the half-period in clk cycles and counts rising edges, for run-time checking of divider settings.

Parameters:
- CNT_W, 32, width of the half-period measurement and its internal counter.
- EDGE_W, 16, width of the rising-edge counter.
- TIMEOUT, 32'd50_000_000, clk cycles without any edge before stalled asserts (used only with STALL_DETECT_EN).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- sclk_in  input  1  slow clock, asynchronous to clk.
- sclk_sync  output  1  synchronized level of sclk_in.
- rise_pulse  output  1  one-cycle strobe per detected rising edge.
- fall_pulse  output  1  one-cycle strobe per detected falling edge.
- half_period  output  CNT_W  last measured clk cycles between consecutive edges.
- meas_valid  output  1  one-cycle strobe when half_period updates.
- meas_ovf  output  1  sticky: a measurement saturated.
- edge_cnt  output  EDGE_W  rising edges counted since reset; wraps.
- stalled  output  1  no edge for TIMEOUT cycles.

Behaviour:
- Reset: all outputs, sync flops s1/s2/s3, the counter and the FSM clear to 0 / INIT asynchronously.
- Reset can occur mid-operation. No pulse or measurement from before reset survives.
- Synchronizer: s1<=sclk_in, s2<=s1, s3<=s2 each cycle; sclk_sync=s2.
- Edge detection: det_r = s2&~s3, det_f = ~s2&s3.
- Pulse latency: rise_pulse/fall_pulse are registered from det_r/det_f.
  - An input edge first sampled at posedge N gives a pulse high in the cycle after posedge N+2.
  - Latency is 3 clk cycles ±1 sampling uncertainty.
- FSM INIT (2 cycles after reset release):
  - Fills the synchronizer.
  - Edge detection is suppressed, so a high sclk_in at release gives no rise_pulse.
  - Then goes to ARM.
- FSM ARM:
  - First detected edge: emit its pulse and clear hcnt; no meas_valid.
  - Then goes to RUN.
- FSM RUN:
  - On each detected edge (either polarity): half_period<=hcnt+1 (saturating at all-ones), meas_valid<=1, hcnt<=0.
  - Otherwise hcnt<=hcnt+1, saturating at all-ones.
- Saturation: if hcnt is all-ones at an edge, half_period=all-ones and meas_ovf<=1. meas_ovf stays set until reset.
- Edge counter: edge_cnt increments on every rise_pulse in ARM or RUN and wraps from all-ones to 0.
- Simultaneous rise and fall within one cycle is impossible by construction (s2/s3 single transition).
- Glitches shorter than a clk period may be missed; this is acceptable.
- Divider check: a divider with compare value M gives half_period = M+1 in steady state.

Optional Feature:
- Macro: CLK_EDGE_MONITOR_STALL_DETECT_EN.
- When defined, in ARM or RUN:
  - stalled<=1 when the idle-cycle count reaches TIMEOUT.
  - It stays 1 until the next detected edge, which clears it in the same cycle its pulse is registered.
- When undefined: stalled is tied to 0, no TIMEOUT comparator is built, and the parameter is ignored.

Decomposition:
- Shared package holds:
  - FSM state encodings: INIT=2'd0, ARM=2'd1, RUN=2'd2.
  - Default widths CNT_W and EDGE_W.
  - The INIT length constant (2).
- One sub-module: sync_2ff, a generic two-flop synchronizer with async active-low reset, reusable elsewhere.
- Edge logic, FSM and counters stay in the top.

Test Plan:
- Steady state: sclk_in from a divider model with compare 3 (toggle every 4 clk) → after ARM, meas_valid every 4 cycles with half_period=4; rise_pulse every 8 cycles; edge_cnt +1 per 8 cycles.
- Reset with sclk_in held high: release rst_n → no rise_pulse, no meas_valid; first pulse appears only on the next real fall (fall_pulse); edge_cnt stays 0.
- Latency: sclk_in rises 1 ns before posedge N → rise_pulse high exactly during cycle N+2→N+3; the pulse is one cycle wide.
- Saturation with CNT_W=4: hold sclk_in 20 cycles between edges → half_period=4'hF, meas_ovf=1, and it stays 1 after later normal measurements of 4.
- Mid-run reset: assert rst_n low for 1 cycle during RUN → all outputs 0 immediately; edge_cnt restarts from 0; the first post-reset edge gives no meas_valid.
- Stall (macro defined, TIMEOUT=10): stop sclk_in → stalled=1 after 10 idle cycles; the next edge clears it and gives meas_valid with half_period saturated or equal to the true count.

Source files
------------

// File: rtl/clk_edge_monitor_pkg.sv
// Shared types and constants for the slow-clock edge monitor.
// FSM encodings, default widths and the synchronizer fill length.
package clk_edge_monitor_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_EDGE_W = 16;
  localparam int INIT_LEN   = 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/clk_edge_monitor_if.sv
// Bundle of slow-clock input and monitor results.
// master drives results (the monitor), slave observes them.
interface clk_edge_monitor_if
  import clk_edge_monitor_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int EDGE_W = DEF_EDGE_W
);

  logic              sclk_in;
  logic              sclk_sync;
  logic              rise_pulse;
  logic              fall_pulse;
  logic [CNT_W-1:0]  half_period;
  logic              meas_valid;
  logic              meas_ovf;
  logic [EDGE_W-1:0] edge_cnt;
  logic              stalled;

  modport master (
    input  sclk_in,
    output sclk_sync,
    output rise_pulse,
    output fall_pulse,
    output half_period,
    output meas_valid,
    output meas_ovf,
    output edge_cnt,
    output stalled
  );

  modport slave (
    output sclk_in,
    input  sclk_sync,
    input  rise_pulse,
    input  fall_pulse,
    input  half_period,
    input  meas_valid,
    input  meas_ovf,
    input  edge_cnt,
    input  stalled
  );

endinterface

// File: rtl/clk_edge_monitor_sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset.
// Reusable for any single-bit or quasi-static bus crossing.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/clk_edge_monitor.sv
// Slow-clock edge strobes, half-period measurement, edge count.
// Stall detector built only with CLK_EDGE_MONITOR_STALL_DETECT_EN.
module clk_edge_monitor
  import clk_edge_monitor_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int          EDGE_W  = DEF_EDGE_W,
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  output logic              sclk_sync,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [CNT_W-1:0]  half_period,
  output logic              meas_valid,
  output logic              meas_ovf,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              stalled
);

  logic s2;
  logic s3_q;
  logic det_r;
  logic det_f;
  logic det;

  mon_state_e        state_q, state_d;
  logic [1:0]        init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  hcnt_inc;
  logic [CNT_W-1:0]  half_period_q, half_period_d;
  logic              meas_valid_q, meas_valid_d;
  logic              meas_ovf_q, meas_ovf_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  sync_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk_in),
    .q     (s2)
  );

  assign det_r = s2 & ~s3_q;
  assign det_f = ~s2 & s3_q;
  assign det   = det_r | det_f;

  assign hcnt_inc = (&hcnt_q) ? hcnt_q
                              : hcnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    hcnt_d        = hcnt_q;
    half_period_d = half_period_q;
    meas_valid_d  = 1'b0;
    meas_ovf_d    = meas_ovf_q;
    edge_cnt_d    = edge_cnt_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;

    unique case (1'b1)
      state_q == ST_INIT: begin
        // det stays masked until s3 holds a real sample
        if (init_cnt_q == 2'(INIT_LEN)) begin
          state_d = ST_ARM;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      state_q == ST_ARM: begin
        rise_d = det_r;
        fall_d = det_f;
        if (det) begin
          hcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          hcnt_d = hcnt_inc;
        end
        if (det_r) edge_cnt_d = edge_cnt_q + 1'b1;
      end
      state_q == ST_RUN: begin
        rise_d = det_r;
        fall_d = det_f;
        if (det) begin
          half_period_d = hcnt_inc;
          meas_valid_d  = 1'b1;
          hcnt_d        = '0;
          if (&hcnt_q) meas_ovf_d = 1'b1;
        end else begin
          hcnt_d = hcnt_inc;
        end
        if (det_r) edge_cnt_d = edge_cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      s3_q          <= 1'b0;
      hcnt_q        <= '0;
      half_period_q <= '0;
      meas_valid_q  <= 1'b0;
      meas_ovf_q    <= 1'b0;
      edge_cnt_q    <= '0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      s3_q          <= s2;
      hcnt_q        <= hcnt_d;
      half_period_q <= half_period_d;
      meas_valid_q  <= meas_valid_d;
      meas_ovf_q    <= meas_ovf_d;
      edge_cnt_q    <= edge_cnt_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
    end
  end

`ifdef CLK_EDGE_MONITOR_STALL_DETECT_EN
  localparam int TW = (CNT_W > 32) ? CNT_W : 32;

  logic stalled_q, stalled_d;

  always_comb begin
    stalled_d = stalled_q;
    if (state_q != ST_INIT) begin
      if (det) begin
        stalled_d = 1'b0;
      end else if (TW'(hcnt_d) >= TW'(TIMEOUT)) begin
        stalled_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stalled_q <= 1'b0;
    else        stalled_q <= stalled_d;
  end

  assign stalled = stalled_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign stalled        = 1'b0;
`endif

  assign sclk_sync   = s2;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign half_period = half_period_q;
  assign meas_valid  = meas_valid_q;
  assign meas_ovf    = meas_ovf_q;
  assign edge_cnt    = edge_cnt_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed bench for clk_edge_monitor with an event scoreboard.
// Define CLK_EDGE_MONITOR_STALL_DETECT_EN to also check stalled.
module tb_clk_edge_monitor;
  import clk_edge_monitor_pkg::*;

  localparam int CW = 4;
  localparam int EW = 4;
  localparam int TO = 10;
  localparam logic [CW-1:0] HMAX = '1;

  typedef struct packed {
    logic          r;
    logic          f;
    logic          mv;
    logic          ovf;
    logic [CW-1:0] hp;
    int            due;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int idle     = 0;

  logic [CW-1:0] hp_m    = '0;
  logic          ovf_m   = 1'b0;
  logic [EW-1:0] ecnt_m  = '0;
  bit            armed_m = 1'b0;
  bit            seen_m  = 1'b0;
  ev_t           q[$];

  clk_edge_monitor_if #(.CNT_W(CW), .EDGE_W(EW)) mon();

  clk_edge_monitor #(
    .CNT_W   (CW),
    .EDGE_W  (EW),
    .TIMEOUT (32'(TO))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_in     (mon.sclk_in),
    .sclk_sync   (mon.sclk_sync),
    .rise_pulse  (mon.rise_pulse),
    .fall_pulse  (mon.fall_pulse),
    .half_period (mon.half_period),
    .meas_valid  (mon.meas_valid),
    .meas_ovf    (mon.meas_ovf),
    .edge_cnt    (mon.edge_cnt),
    .stalled     (mon.stalled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_sync"}, 32'(mon.sclk_sync), 0);
    chk({pfx, "_rise"}, 32'(mon.rise_pulse), 0);
    chk({pfx, "_fall"}, 32'(mon.fall_pulse), 0);
    chk({pfx, "_hp"}, 32'(mon.half_period), 0);
    chk({pfx, "_mv"}, 32'(mon.meas_valid), 0);
    chk({pfx, "_ovf"}, 32'(mon.meas_ovf), 0);
    chk({pfx, "_ecnt"}, 32'(mon.edge_cnt), 0);
    chk({pfx, "_stall"}, 32'(mon.stalled), 0);
  endtask

  task automatic model_clear();
    q.delete();
    hp_m    = '0;
    ovf_m   = 1'b0;
    ecnt_m  = '0;
    armed_m = 1'b0;
    seen_m  = 1'b0;
    idle    = 0;
  endtask

  // One clock: pop the event due now, then check held state.
  task automatic tick();
    ev_t        e;
    logic [2:0] act;
    @(negedge clk);
    cyc++;
    idle++;
    act = {mon.rise_pulse, mon.fall_pulse, mon.meas_valid};
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("event", 32'(act), 32'({e.r, e.f, e.mv}));
      if (e.mv) hp_m = e.hp;
      if (e.mv && e.ovf) ovf_m = 1'b1;
      if (e.r) ecnt_m = ecnt_m + 1'b1;
      seen_m = 1'b1;
      idle   = 0;
    end else begin
      chk("no_event", 32'(act), 0);
    end
    chk("half_period", 32'(mon.half_period), 32'(hp_m));
    chk("meas_ovf", 32'(mon.meas_ovf), 32'(ovf_m));
    chk("edge_cnt", 32'(mon.edge_cnt), 32'(ecnt_m));
`ifdef CLK_EDGE_MONITOR_STALL_DETECT_EN
    if (seen_m)
      chk("stalled", 32'(mon.stalled), 32'(idle >= TO));
`else
    chk("stalled", 32'(mon.stalled), 0);
`endif
  endtask

  task automatic drive_edge(input int gap);
    ev_t e;
    int  g;
    repeat (gap) tick();
    g        = cyc - last_cyc;
    last_cyc = cyc;
    mon.sclk_in = ~mon.sclk_in;
    e.r   = mon.sclk_in;
    e.f   = ~mon.sclk_in;
    e.mv  = armed_m;
    e.ovf = armed_m && (g - 1 >= int'(HMAX));
    e.hp  = (g >= int'(HMAX)) ? HMAX : CW'(g);
    e.due = cyc + 3;
    q.push_back(e);
    armed_m = 1'b1;
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    #1;
    chk_zero("rst");
    model_clear();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    mon.sclk_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_zero("por");
    tick();
    tick();
    rst_n = 1'b1;

    // steady state: divider compare 3, edge counter wraps
    drive_edge(5);
    for (int i = 0; i < 40; i++) drive_edge(4);
    repeat (3) tick();
    chk("sclk_sync", 32'(mon.sclk_sync),
        32'(mon.sclk_in));

    // latency of a single rising edge
    if (mon.sclk_in) drive_edge(4);
    drive_edge(6);
    tick(); chk("lat1", 32'(mon.rise_pulse), 0);
    tick(); chk("lat2", 32'(mon.rise_pulse), 0);
    tick(); chk("lat3", 32'(mon.rise_pulse), 1);
    tick(); chk("lat4", 32'(mon.rise_pulse), 0);

    // saturation boundary, then sticky overflow
    drive_edge(0);
    drive_edge(15);
    drive_edge(16);
    drive_edge(20);
    for (int i = 0; i < 4; i++) drive_edge(4);
    repeat (3) tick();
    chk("ovf_sticky", 32'(mon.meas_ovf), 1);

    // mid-run reset while a pulse is high
    drive_edge(4);
    repeat (3) tick();
    reset_cycle();
    drive_edge(5);
    for (int i = 0; i < 6; i++) drive_edge(4);

    // reset with sclk held high: first edge is a fall
    if (!mon.sclk_in) drive_edge(4);
    repeat (4) tick();
    reset_cycle();
    repeat (10) tick();
    chk("hi_ecnt", 32'(mon.edge_cnt), 0);
    drive_edge(0);
    repeat (3) tick();
    chk("hi_fall_ecnt", 32'(mon.edge_cnt), 0);
    for (int i = 0; i < 4; i++) drive_edge(4);

    // input stops, then resumes
    repeat (14) tick();
    drive_edge(0);
    drive_edge(4);
    repeat (6) tick();
    chk("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
